// File: rtl/slice_collector_pkg.sv
// Shared sizing and state encoding for the slice collector and its row register.
package slice_collector_pkg;

  localparam int N_DEF   = 5;
  localparam int SLICE_W = N_DEF * N_DEF;
  localparam int IDX_W   = $clog2(N_DEF);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/slice_collector_slice_row_reg.sv
// N*N slice storage, one N-bit row written per accepted beat; write lands on the next edge.
// No handshake of its own: the collector decides when a row write happens.
module slice_row_reg
  import slice_collector_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  logic [$clog2(N)-1:0]   wr_idx,
  input  logic [N-1:0]           wr_row,
  output logic [N*N-1:0]         slice
);

  localparam int IW = $clog2(N);

  // Row r occupies slice[r*N +: N], so bit index is row*N + col.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slice <= '0;
    end else begin
      for (int r = 0; r < N; r++) begin
        if (wr && (wr_idx == IW'(r))) begin
          slice[r*N +: N] <= wr_row;
        end
      end
    end
  end

endmodule

// File: rtl/slice_collector.sv
// Collects N rows into an N*N slice; out_valid rises one cycle after the last row is accepted.
// While a slice is held, in_ready follows out_ready so row 0 of the next slice can overlap the drain.
module slice_collector
  import slice_collector_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic [N-1:0]           in_row,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N*N-1:0]         out_slice,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   row_idx
);

  localparam int             IW   = $clog2(N);
  localparam logic [IW-1:0]  LAST = IW'(N - 1);

  state_t         state;
  state_t         state_nxt;
  logic [IW-1:0]  idx_nxt;
  logic           accept;

  assign in_ready  = (state == FILL) || out_ready;
  assign out_valid = (state == FULL);
  // clr suppresses the row write as well as the state change.
  assign accept    = in_valid && in_ready && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      row_idx <= '0;
    end else begin
      state   <= state_nxt;
      row_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = row_idx;
    if (clr) begin
      state_nxt = FILL;
      idx_nxt   = '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            if (row_idx == LAST) begin
              state_nxt = FULL;
              idx_nxt   = '0;
            end else begin
              idx_nxt = row_idx + 1'b1;
            end
          end
        end
        FULL: begin
          // A row accepted here is row 0 of the next slice (row_idx is already 0).
          if (out_ready) begin
            state_nxt = FILL;
            idx_nxt   = accept ? IW'(1) : '0;
          end
        end
        default: begin
          state_nxt = FILL;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  slice_row_reg #(.N(N)) u_rows (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr     (accept),
    .wr_idx (row_idx),
    .wr_row (in_row),
    .slice  (out_slice)
  );

endmodule

// File: doc/slice_collector.md
SLICE_COLLECTOR -- requirements
Module: slice_collector

Interface
REQ-001 Parameter N, default 5: side length of the square slice (N*N bits), N >= 2.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 clr  input  1  synchronous clear; discards partial and held slice.
REQ-005 in_row  input  N  one slice row; bit c is column c.
REQ-006 in_valid  input  1  in_row is valid this cycle.
REQ-007 in_ready  output  1  collector accepts in_row this cycle.
REQ-008 out_slice  output  N*N  assembled slice feeding the downstream mapper stage.
REQ-009 out_valid  output  1  out_slice holds a complete slice.
REQ-010 out_ready  input  1  downstream consumes out_slice this cycle.
REQ-011 row_idx  output  clog2(N)  index of the next row to be written.

Function
REQ-012 Input beat accepted iff in_valid && in_ready at a rising edge; output beat iff out_valid && out_ready.
REQ-013 Accepted rows fill in order 0..N-1; row r SHALL be written to out_slice[r*N +: N] (index = row*N + col).
REQ-014 States: FILL (out_valid=0, collecting) and FULL (out_valid=1, holding).
REQ-015 FILL: in_ready=1; each accepted row increments row_idx; accepting row N-1 SHALL set row_idx=0 and move to FULL, so out_valid is 1 in the cycle after the last row's edge (latency 1 cycle).
REQ-016 FULL: out_slice and out_valid SHALL stay stable until out_ready=1; in_ready = out_ready.
REQ-017 FULL with out_ready=1 and no input: go to FILL, row_idx=0, out_valid=0 next cycle.
REQ-018 FULL with out_ready=1 and in_valid=1 (simultaneous): consume slice and accept row 0 of next slice in same cycle; next state FILL, row_idx=1; no bubble.
REQ-019 N=1-row edge case excluded by REQ-001; row_idx SHALL never exceed N-1.
REQ-020 out_slice bits of rows not yet written in the current fill are don't-care while out_valid=0; bench SHALL not check them.
REQ-021 clr=1 SHALL, at the next edge, force FILL, row_idx=0, out_valid=0, and ignore any same-cycle input or output beat; clr has priority over all handshakes.
REQ-022 in_valid without in_ready SHALL not alter state; in_row is sampled only on accepted beats.

Reset
REQ-023 rst_n low SHALL immediately force FILL, row_idx=0, out_valid=0, out_slice=0, regardless of clk.
REQ-024 Reset mid-fill or mid-hold SHALL drop the partial/held slice; first row accepted after release is row 0.
REQ-025 in_ready SHALL be 1 from the first cycle after reset release.

Structure
REQ-026 Shared package holds N default, slice width N*N, row-index width clog2(N), and the state encoding (FILL=0, FULL=1).
REQ-027 One sub-module, slice_row_reg: N*N register with per-row write enable, decoded from row_idx and accept.
REQ-028 Control (state, row_idx, handshake) SHALL reside in slice_collector; no combinational path from in_valid to out_valid.

Verification
REQ-029 N=5, out_ready=1, rows 0x01,0x02,0x04,0x08,0x10 on consecutive cycles -> out_valid one cycle after 5th row, out_slice=0x1041041 (bit r*5+r set).
REQ-030 Fill slice of all 0x1F, out_ready=0 for 4 cycles -> out_valid and out_slice=0x1FFFFFF stable, in_ready=0 throughout.
REQ-031 FULL, out_ready=1 and in_valid=1 with row 0x15 same cycle -> out beat taken, row_idx=1 next cycle, new slice bits[4:0]=0x15.
REQ-032 Three rows accepted, then clr=1 with in_valid=1 -> row_idx=0, out_valid=0; next 5 rows form a fresh slice.
REQ-033 rst_n asserted mid-cycle while FULL -> out_valid=0 and out_slice=0 before next clk edge; after release row_idx=0, in_ready=1.
REQ-034 Random in_valid/out_ready gaps, 200 slices -> every out beat equals scoreboard slice; no loss, duplication, or reordering.
